k12_alu: RTL and testbench

Arithmetic/logic and condition unit of the K12 core. It combinationally computes an 8-bit result and a 1-bit condition from two register operands and the current 16-bit instruction word. It holds one architectural carry flag, updated on the clock, which feeds ADC/SBC and the carry-test conditions. The sequencer writes `res` to the register file and uses `cond` for conditional skips and branches.

---
 rtl/k12_alu.sv | 91 +++++++++
 tb/tb_k12_alu.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/k12_alu.sv
// rtl/k12_alu.sv - K12 arithmetic/logic and condition unit with architectural carry flag
module k12_alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [15:0] inst,
    output logic [7:0]  res,
    output logic        cond
);

    logic        c_flag;
    logic [7:0]  opb;
    logic [4:0]  f;
    logic [8:0]  add_sum;
    logic [8:0]  sub_sum;
    logic        add_cin;
    logic        sub_cin;
    logic [7:0]  res_v;
    logic        cond_v;
    logic        co;
    logic        c_wr;

    assign opb = inst[13] ? inst[7:0] : b;
    assign f   = inst[12:8];

    // ADC/SBC take the stored carry; plain ADD has no carry-in and SUB forces +1
    assign add_cin = (f == 5'b00001) ? c_flag : 1'b0;
    assign sub_cin = (f == 5'b00011) ? c_flag : 1'b1;
    assign add_sum = {1'b0, a} + {1'b0, opb} + {8'b0, add_cin};
    assign sub_sum = {1'b0, a} + {1'b0, ~opb} + {8'b0, sub_cin};

    // Result, condition and carry-out selection from the function field
    always_comb begin
        res_v  = a;
        cond_v = 1'b0;
        co     = 1'b0;
        c_wr   = 1'b0;
        if (!f[4]) begin
            case (f[3:0])
                4'b0000, 4'b0001: begin res_v = add_sum[7:0]; co = add_sum[8]; c_wr = 1'b1; end
                4'b0010, 4'b0011: begin res_v = sub_sum[7:0]; co = sub_sum[8]; c_wr = 1'b1; end
                4'b0100: res_v = a & opb;
                4'b0101: res_v = a | opb;
                4'b0110: res_v = a ^ opb;
                4'b0111: res_v = opb;
                4'b1000: begin res_v = {a[6:0], 1'b0}; co = a[7]; c_wr = 1'b1; end
                4'b1001: begin res_v = {1'b0, a[7:1]}; co = a[0]; c_wr = 1'b1; end
                4'b1010: begin res_v = {a[7], a[7:1]}; co = a[0]; c_wr = 1'b1; end
                4'b1011: res_v = {a[6:0], a[7]};
                4'b1100: res_v = {a[0], a[7:1]};
                4'b1101: res_v = ~a;
                4'b1110: res_v = a + 8'd1;
                default: res_v = a - 8'd1;
            endcase
            cond_v = (res_v == 8'h00);
        end else begin
            case (f[3:0])
                4'b0000: cond_v = (a == opb);
                4'b0001: cond_v = (a != opb);
                4'b0010: cond_v = (a < opb);
                4'b0011: cond_v = (a >= opb);
                4'b0100: cond_v = ($signed(a) < $signed(opb));
                4'b0101: cond_v = ($signed(a) >= $signed(opb));
                4'b0110: cond_v = (a <= opb);
                4'b0111: cond_v = (a > opb);
                4'b1000: cond_v = ($signed(a) <= $signed(opb));
                4'b1001: cond_v = ($signed(a) > $signed(opb));
                4'b1010: cond_v = ((a & opb) == 8'h00);
                4'b1011: cond_v = ((a & opb) != 8'h00);
                4'b1100: cond_v = c_flag;
                4'b1101: cond_v = ~c_flag;
                4'b1110: cond_v = 1'b1;
                default: cond_v = 1'b0;
            endcase
        end
    end

    assign res  = res_v;
    assign cond = cond_v;

    // Carry flag: only ALU-class instructions with a carry-producing function update it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_flag <= 1'b0;
        end else if (inst[15:14] == 2'b00 && c_wr) begin
            c_flag <= co;
        end
    end

endmodule

// File: tb/tb_k12_alu.sv
// tb/tb_k12_alu.sv - directed self-checking bench for k12_alu
module tb_k12_alu;

    logic        clk;
    logic        rst_n;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] inst;
    logic [7:0]  res;
    logic        cond;

    int vecs = 0;
    int errs = 0;

    k12_alu dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .b    (b),
        .inst (inst),
        .res  (res),
        .cond (cond)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // drive one instruction just after a falling edge and let it settle
    task automatic drive(input logic [15:0] i, input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        inst = i; a = av; b = bv;
        #1;
    endtask

    // clock the current instruction, then switch to CS so cond shows C
    task automatic clock_then_cs;
        @(posedge clk);
        #1;
        inst = 16'h1C00;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(16'h1C00, 8'h5A, 8'h00);
        vecs++; if (cond !== 1'b0) begin $display("FAIL reset_cs got %b want %b", cond, 1'b0); errs++; end
        vecs++; if (res !== 8'h5A) begin $display("FAIL reset_cmp_res got %h want %h", res, 8'h5A); errs++; end
        drive(16'h0000, 8'hFF, 8'h01);
        clock_then_cs;
        vecs++; if (cond !== 1'b0) begin $display("FAIL reset_hold_c got %b want %b", cond, 1'b0); errs++; end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        drive(16'h0000, 8'h7F, 8'h01);
        vecs++; if (res !== 8'h80) begin $display("FAIL add_res got %h want %h", res, 8'h80); errs++; end
        vecs++; if (cond !== 1'b0) begin $display("FAIL add_cond got %b want %b", cond, 1'b0); errs++; end
        clock_then_cs;
        vecs++; if (cond !== 1'b0) begin $display("FAIL add_c got %b want %b", cond, 1'b0); errs++; end
        drive(16'h0000, 8'hFF, 8'h01);
        vecs++; if (res !== 8'h00) begin $display("FAIL add_wrap_res got %h want %h", res, 8'h00); errs++; end
        vecs++; if (cond !== 1'b1) begin $display("FAIL add_wrap_cond got %b want %b", cond, 1'b1); errs++; end
        clock_then_cs;
        vecs++; if (cond !== 1'b1) begin $display("FAIL add_wrap_c got %b want %b", cond, 1'b1); errs++; end
        drive(16'h0100, 8'h00, 8'h00);
        vecs++; if (res !== 8'h01) begin $display("FAIL adc_res got %h want %h", res, 8'h01); errs++; end
    endtask

    task automatic test_sub;
        drive(16'h0200, 8'h00, 8'h01);
        vecs++; if (res !== 8'hFF) begin $display("FAIL sub_res got %h want %h", res, 8'hFF); errs++; end
        clock_then_cs;
        vecs++; if (cond !== 1'b0) begin $display("FAIL sub_borrow_c got %b want %b", cond, 1'b0); errs++; end
        drive(16'h1D00, 8'h00, 8'h00);
        vecs++; if (cond !== 1'b1) begin $display("FAIL cc_cond got %b want %b", cond, 1'b1); errs++; end
        drive(16'h0300, 8'h05, 8'h02);
        vecs++; if (res !== 8'h02) begin $display("FAIL sbc_res got %h want %h", res, 8'h02); errs++; end
        clock_then_cs;
        vecs++; if (cond !== 1'b1) begin $display("FAIL sbc_c got %b want %b", cond, 1'b1); errs++; end
        drive(16'h0300, 8'h05, 8'h02);
        vecs++; if (res !== 8'h03) begin $display("FAIL sbc_c1_res got %h want %h", res, 8'h03); errs++; end
    endtask

    task automatic test_imm_compare;
        drive(16'h20FE, 8'h01, 8'h33);
        vecs++; if (res !== 8'hFF) begin $display("FAIL imm_add_res got %h want %h", res, 8'hFF); errs++; end
        drive(16'h1400, 8'h80, 8'h7F);
        vecs++; if (cond !== 1'b1) begin $display("FAIL slt_cond got %b want %b", cond, 1'b1); errs++; end
        vecs++; if (res !== 8'h80) begin $display("FAIL slt_res got %h want %h", res, 8'h80); errs++; end
        drive(16'h1200, 8'h80, 8'h7F);
        vecs++; if (cond !== 1'b0) begin $display("FAIL ult_cond got %b want %b", cond, 1'b0); errs++; end
        drive(16'h1700, 8'h80, 8'h7F);
        vecs++; if (cond !== 1'b1) begin $display("FAIL ugt_cond got %b want %b", cond, 1'b1); errs++; end
        drive(16'h1900, 8'h80, 8'h7F);
        vecs++; if (cond !== 1'b0) begin $display("FAIL sgt_cond got %b want %b", cond, 1'b0); errs++; end
        drive(16'h1800, 8'h80, 8'h80);
        vecs++; if (cond !== 1'b1) begin $display("FAIL sle_eq_cond got %b want %b", cond, 1'b1); errs++; end
        drive(16'h1600, 8'h7F, 8'h80);
        vecs++; if (cond !== 1'b1) begin $display("FAIL ule_cond got %b want %b", cond, 1'b1); errs++; end
        drive(16'h3080, 8'h80, 8'h00);
        vecs++; if (cond !== 1'b1) begin $display("FAIL imm_eq_cond got %b want %b", cond, 1'b1); errs++; end
        drive(16'h1A00, 8'hF0, 8'h0F);
        vecs++; if (cond !== 1'b1) begin $display("FAIL tz_cond got %b want %b", cond, 1'b1); errs++; end
        drive(16'h1B00, 8'hF1, 8'h0F);
        vecs++; if (cond !== 1'b1) begin $display("FAIL tnz_cond got %b want %b", cond, 1'b1); errs++; end
        drive(16'h1E00, 8'h00, 8'h00);
        vecs++; if (cond !== 1'b1) begin $display("FAIL always1 got %b want %b", cond, 1'b1); errs++; end
        drive(16'h1F00, 8'h00, 8'h00);
        vecs++; if (cond !== 1'b0) begin $display("FAIL always0 got %b want %b", cond, 1'b0); errs++; end
    endtask

    task automatic test_logic;
        drive(16'h0400, 8'hF0, 8'h3C);
        vecs++; if (res !== 8'h30) begin $display("FAIL and_res got %h want %h", res, 8'h30); errs++; end
        drive(16'h0500, 8'hF0, 8'h3C);
        vecs++; if (res !== 8'hFC) begin $display("FAIL or_res got %h want %h", res, 8'hFC); errs++; end
        drive(16'h0600, 8'hF0, 8'h3C);
        vecs++; if (res !== 8'hCC) begin $display("FAIL xor_res got %h want %h", res, 8'hCC); errs++; end
        drive(16'h0700, 8'hF0, 8'h3C);
        vecs++; if (res !== 8'h3C) begin $display("FAIL mov_res got %h want %h", res, 8'h3C); errs++; end
        drive(16'h0D00, 8'hF0, 8'h00);
        vecs++; if (res !== 8'h0F) begin $display("FAIL not_res got %h want %h", res, 8'h0F); errs++; end
        drive(16'h0F00, 8'h00, 8'h00);
        vecs++; if (res !== 8'hFF) begin $display("FAIL dec_res got %h want %h", res, 8'hFF); errs++; end
        drive(16'h0B00, 8'h81, 8'h00);
        vecs++; if (res !== 8'h03) begin $display("FAIL rol_res got %h want %h", res, 8'h03); errs++; end
    endtask

    task automatic test_shifts;
        drive(16'h0900, 8'h02, 8'h00);
        vecs++; if (res !== 8'h01) begin $display("FAIL shr_res got %h want %h", res, 8'h01); errs++; end
        clock_then_cs;
        vecs++; if (cond !== 1'b0) begin $display("FAIL shr_c got %b want %b", cond, 1'b0); errs++; end
        drive(16'h0A00, 8'h81, 8'h00);
        vecs++; if (res !== 8'hC0) begin $display("FAIL asr_res got %h want %h", res, 8'hC0); errs++; end
        clock_then_cs;
        vecs++; if (cond !== 1'b1) begin $display("FAIL asr_c got %b want %b", cond, 1'b1); errs++; end
        drive(16'h0C00, 8'h81, 8'h00);
        vecs++; if (res !== 8'hC0) begin $display("FAIL ror_res got %h want %h", res, 8'hC0); errs++; end
        drive(16'h0C00, 8'h80, 8'h00);
        clock_then_cs;
        vecs++; if (cond !== 1'b1) begin $display("FAIL ror_hold_c got %b want %b", cond, 1'b1); errs++; end
        drive(16'h0800, 8'h01, 8'h00);
        vecs++; if (res !== 8'h02) begin $display("FAIL shl_res got %h want %h", res, 8'h02); errs++; end
        clock_then_cs;
        vecs++; if (cond !== 1'b0) begin $display("FAIL shl_c got %b want %b", cond, 1'b0); errs++; end
        drive(16'h0E00, 8'hFF, 8'h00);
        vecs++; if (res !== 8'h00) begin $display("FAIL inc_res got %h want %h", res, 8'h00); errs++; end
        clock_then_cs;
        vecs++; if (cond !== 1'b0) begin $display("FAIL inc_hold_c got %b want %b", cond, 1'b0); errs++; end
        drive(16'h4000, 8'hFF, 8'h01);
        vecs++; if (res !== 8'h00) begin $display("FAIL class1_res got %h want %h", res, 8'h00); errs++; end
        clock_then_cs;
        vecs++; if (cond !== 1'b0) begin $display("FAIL class1_hold_c got %b want %b", cond, 1'b0); errs++; end
    endtask

    task automatic test_async_reset;
        drive(16'h0000, 8'hFF, 8'h01);
        clock_then_cs;
        vecs++; if (cond !== 1'b1) begin $display("FAIL pre_reset_c got %b want %b", cond, 1'b1); errs++; end
        #1;
        rst_n = 1'b0;
        #1;
        vecs++; if (cond !== 1'b0) begin $display("FAIL async_clear_c got %b want %b", cond, 1'b0); errs++; end
        drive(16'h0000, 8'hFF, 8'h01);
        rst_n = 1'b1;
        clock_then_cs;
        vecs++; if (cond !== 1'b1) begin $display("FAIL first_edge_c got %b want %b", cond, 1'b1); errs++; end
    endtask

    initial begin
        rst_n = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        inst  = 16'h0000;
        test_reset;
        test_add;
        test_sub;
        test_imm_compare;
        test_logic;
        test_shifts;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
